// File: rtl/linked_list_reader.sv
// Pop-side consumer for the shared linked-list FIFO: round-robin pops, 2-entry output buffer, per-queue drain.
// Optional pop counter on pop_total when LL_READER_STATS_EN is defined.
module linked_list_reader #(
  parameter int WIDTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel,
  input  logic                 drain_req,
  input  logic [SEL_WIDTH-1:0] drain_sel,
  output logic                 draining,
  output logic                 drain_done,
  output logic [15:0]          pop_total
);

  typedef enum logic [1:0] {ARB, DRAIN, DONE} state_t;

  state_t               state;
  logic [SEL_WIDTH-1:0] rr_ptr;
  logic [SEL_WIDTH-1:0] drain_q;
  logic [SEL_WIDTH-1:0] last_sel;
  logic [SEL_WIDTH-1:0] cand_sel;
  logic                 cand_ok;
  logic [SEL_WIDTH-1:0] scan_idx [NUM_FIFOS];

  logic [1:0]           count;
  logic                 head;
  logic                 wr_idx;
  logic                 xfer;
  logic [WIDTH-1:0]     buf_data [2];
  logic [SEL_WIDTH-1:0] buf_sel  [2];

  always_comb begin
    for (int k = 0; k < NUM_FIFOS; k++)
      scan_idx[k] = SEL_WIDTH'((int'(rr_ptr) + k) % NUM_FIFOS);
  end

  // Scan from the far end so the lowest offset from rr_ptr wins.
  always_comb begin
    cand_ok  = 1'b0;
    cand_sel = last_sel;
    case (state)
      ARB: begin
        for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
          if (!empty[scan_idx[k]]) begin
            cand_ok  = 1'b1;
            cand_sel = scan_idx[k];
          end
        end
      end
      DRAIN: begin
        if (!empty[drain_q]) begin
          cand_ok  = 1'b1;
          cand_sel = drain_q;
        end
      end
      default: ;
    endcase
  end

  assign pop     = cand_ok && (count != 2'd2) && !rst;
  assign pop_sel = pop ? cand_sel : last_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      drain_q    <= '0;
      last_sel   <= '0;
      draining   <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      if (pop) last_sel <= pop_sel;
      case (state)
        ARB: begin
          if (pop)
            rr_ptr <= (pop_sel == SEL_WIDTH'(NUM_FIFOS - 1)) ? '0 : pop_sel + 1'b1;
          if (drain_req) begin
            state    <= DRAIN;
            draining <= 1'b1;
            // An out-of-range queue number falls back to queue 0.
            drain_q  <= (int'(drain_sel) < NUM_FIFOS) ? drain_sel : '0;
          end
        end
        DRAIN: begin
          if (empty[drain_q]) begin
            state      <= DONE;
            draining   <= 1'b0;
            drain_done <= 1'b1;
          end
        end
        default: begin
          state      <= ARB;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = (count != 2'd0);
  assign out_data  = buf_data[head];
  assign out_sel   = buf_sel[head];
  assign xfer      = out_valid && out_ready;
  assign wr_idx    = head ^ count[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      head        <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_sel[0]  <= '0;
      buf_sel[1]  <= '0;
    end else begin
      if (pop) begin
        buf_data[wr_idx] <= fifo_data;
        buf_sel[wr_idx]  <= pop_sel;
      end
      if (xfer) head <= ~head;
      count <= count + {1'b0, pop} - {1'b0, xfer};
    end
  end

`ifdef LL_READER_STATS_EN
  logic [15:0] pop_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      pop_cnt <= '0;
    else if (pop)
      pop_cnt <= pop_cnt + 16'd1;
  end

  assign pop_total = pop_cnt;
`else
  assign pop_total = '0;
`endif

endmodule

// File: tb/tb_linked_list_reader.sv
// Randomized bench for linked_list_reader; the bench emulates the shared FIFO and
// predicts pops and the output stream from queue contents and the arbitration rules.
module tb_linked_list_reader;
  localparam int W  = 4;
  localparam int N  = 2;
  localparam int SW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  empty;
  logic [W-1:0]  fifo_data;
  logic          pop;
  logic [SW-1:0] pop_sel;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;
  logic          drain_req;
  logic [SW-1:0] drain_sel;
  logic          draining;
  logic          drain_done;
  logic [15:0]   pop_total;

  linked_list_reader #(.WIDTH(W), .NUM_FIFOS(N)) dut (
    .clk(clk), .rst(rst), .empty(empty), .fifo_data(fifo_data),
    .pop(pop), .pop_sel(pop_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .drain_req(drain_req), .drain_sel(drain_sel),
    .draining(draining), .drain_done(drain_done), .pop_total(pop_total)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
  } ent_t;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] qm [N][$];
  ent_t         sb [$];
  int           m_mode;   // 0 = round robin, 1 = draining, 2 = drain complete
  int           m_rr, m_dq, m_last, m_pops;

`ifdef LL_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  function automatic void refresh_empty();
    for (int i = 0; i < N; i++) empty[i] = (qm[i].size() == 0);
  endfunction

  function automatic void model_reset();
    sb.delete();
    m_mode = 0; m_rr = 0; m_dq = 0; m_last = 0; m_pops = 0;
  endfunction

  task automatic push_word(input int q, input logic [W-1:0] v);
    qm[q].push_back(v);
    refresh_empty();
  endtask

  // One clock: check at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit   exp_pop, xfer;
    int   exp_sel, next_mode;
    ent_t e;
    logic [15:0] exp_total;
    @(negedge clk);
    if ($isunknown(pop_sel) || qm[pop_sel].size() == 0) fifo_data = '0;
    else fifo_data = qm[pop_sel][0];
    exp_pop = 1'b0;
    exp_sel = m_last;
    if (sb.size() < 2) begin
      if (m_mode == 0) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (!exp_pop && qm[i].size() != 0) begin
            exp_pop = 1'b1;
            exp_sel = i;
          end
        end
      end else if (m_mode == 1 && qm[m_dq].size() != 0) begin
        exp_pop = 1'b1;
        exp_sel = m_dq;
      end
    end
    checks++;
    if (pop !== exp_pop) begin
      errors++; $display("FAIL pop: got %b expected %b at %0t", pop, exp_pop, $time);
    end
    checks++;
    if (pop_sel !== SW'(exp_sel)) begin
      errors++; $display("FAIL pop_sel: got %0d expected %0d at %0t", pop_sel, exp_sel, $time);
    end
    checks++;
    if (out_valid !== (sb.size() != 0)) begin
      errors++; $display("FAIL out_valid: got %b expected %b at %0t", out_valid, sb.size() != 0, $time);
    end
    if (sb.size() != 0) begin
      checks++;
      if (out_data !== sb[0].d || out_sel !== sb[0].s) begin
        errors++;
        $display("FAIL out_word: got data %h sel %0d expected data %h sel %0d at %0t",
                 out_data, out_sel, sb[0].d, sb[0].s, $time);
      end
    end
    checks++;
    if (draining !== (m_mode == 1)) begin
      errors++; $display("FAIL draining: got %b expected %b at %0t", draining, m_mode == 1, $time);
    end
    checks++;
    if (drain_done !== (m_mode == 2)) begin
      errors++; $display("FAIL drain_done: got %b expected %b at %0t", drain_done, m_mode == 2, $time);
    end
    exp_total = STATS ? 16'(m_pops) : 16'd0;
    checks++;
    if (pop_total !== exp_total) begin
      errors++; $display("FAIL pop_total: got %0d expected %0d at %0t", pop_total, exp_total, $time);
    end
    xfer = (sb.size() != 0) && out_ready;
    next_mode = m_mode;
    case (m_mode)
      0: if (drain_req) begin next_mode = 1; m_dq = drain_sel; end
      1: if (qm[m_dq].size() == 0) next_mode = 2;
      default: next_mode = 0;
    endcase
    @(posedge clk);
    if (xfer) void'(sb.pop_front());
    if (exp_pop) begin
      e.d = qm[exp_sel].pop_front();
      e.s = SW'(exp_sel);
      sb.push_back(e);
      if (m_mode == 0) m_rr = (exp_sel + 1) % N;
      m_last = exp_sel;
      m_pops++;
    end
    m_mode = next_mode;
    #1;
    refresh_empty();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0; drain_req = 1'b0; drain_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pop !== 1'b0 || pop_sel !== '0 || out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 ||
        draining !== 1'b0 || drain_done !== 1'b0 || pop_total !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: pop %b sel %0d valid %b data %h osel %0d drn %b done %b total %0d, all expected 0",
               pop, pop_sel, out_valid, out_data, out_sel, draining, drain_done, pop_total);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    refresh_empty();
  endtask

  task automatic test_round_robin();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_word(0, W'($urandom));
      push_word(1, W'($urandom));
    end
    run(12);
  endtask

  task automatic test_skip_empty();
    out_ready = 1'b1;
    push_word(1, 4'hA);
    push_word(1, 4'hB);
    run(6);
  endtask

  task automatic test_backpressure();
    int p0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_word(0, W'($urandom));
      push_word(1, W'($urandom));
    end
    p0 = m_pops;
    run(5);
    checks++;
    if (pop_total !== (STATS ? 16'(p0 + 2) : 16'd0)) begin
      errors++; $display("FAIL backpressure_pops: got total %0d after stall, expected two more than %0d", pop_total, p0);
    end
    out_ready = 1'b1;
    run(10);
  endtask

  task automatic test_drain();
    int done_pulses;
    out_ready = 1'b1;
    drain_req = 1'b1; drain_sel = 1'b1;
    cycle();
    drain_req = 1'b0;
    for (int i = 0; i < 3; i++) push_word(1, W'($urandom));
    for (int i = 0; i < 2; i++) push_word(0, W'($urandom));
    done_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (drain_done === 1'b1) done_pulses++;
    end
    checks++;
    if (done_pulses != 1) begin
      errors++; $display("FAIL drain_done_pulses: got %0d expected 1", done_pulses);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(0, W'($urandom));
    run(3);
    drain_req = 1'b1; drain_sel = 1'b0;
    cycle();
    drain_req = 1'b0;
    run(2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || draining !== 1'b0 || pop !== 1'b0 || drain_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid %b draining %b pop %b done %b, all expected 0",
               out_valid, draining, pop, drain_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    push_word(1, W'($urandom));
    push_word(1, W'($urandom));
    out_ready = 1'b1;
    run(8);
  endtask

  task automatic test_stats();
    test_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(i % N, W'($urandom));
    run(10);
    checks++;
    if (pop_total !== (STATS ? 16'd5 : 16'd0)) begin
      errors++; $display("FAIL pop_total_five: got %0d expected %0d", pop_total, STATS ? 5 : 0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drain_req = ($urandom_range(0, 39) == 0);
      drain_sel = SW'($urandom_range(0, N - 1));
      for (int q = 0; q < N; q++)
        if (qm[q].size() < 6 && $urandom_range(0, 2) == 0) push_word(q, W'($urandom));
      cycle();
    end
    drain_req = 1'b0;
    out_ready = 1'b1;
    run(30);
  endtask

  initial begin
    rst = 1'b1; empty = '1; fifo_data = '0;
    out_ready = 1'b0; drain_req = 1'b0; drain_sel = '0;
    for (int i = 0; i < N; i++) qm[i].delete();
    model_reset();
    test_reset();
    test_round_robin();
    test_skip_empty();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_stats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
